// File: rtl/jalu_reg.sv
// Registered N-bit ALU stage with a persistent {C, A, E, Z} flags register.
// The stored carry can feed the next op's carry-in for multi-word add/shift chains.
module jalu_reg #(
  parameter int N = 8
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         wvalid,
  input  logic [2:0]   bop,
  input  logic [N-1:0] ba,
  input  logic [N-1:0] bb,
  input  logic         wuse_cf,
  input  logic         wclrf,
  output logic [N-1:0] bres,
  output logic         wres_valid,
  output logic         wres_we,
  output logic [3:0]   bflags
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SHR = 3'b001,
    OP_SHL = 3'b010,
    OP_NOT = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  logic [N-1:0] r_res;
  logic         r_valid;
  logic         r_we;
  logic [3:0]   r_flags;

  logic         w_ci;
  logic [N-1:0] w_sum;
  logic         w_sum_co;
  logic [N-1:0] w_res;
  logic         w_co;
  logic         w_gt;
  logic         w_eq;

  // Carry-in always comes from the flags as they stood before this edge.
  assign w_ci = wuse_cf & r_flags[3];
  assign w_gt = (ba > bb);
  assign w_eq = (ba == bb);

  always_comb begin : ripple
    logic v_c;
    v_c   = w_ci;
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum[i] = ba[i] ^ bb[i] ^ v_c;
      v_c      = (ba[i] & bb[i]) | (ba[i] & v_c) | (bb[i] & v_c);
    end
    w_sum_co = v_c;
  end

  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    case (bop)
      OP_ADD: begin
        w_res = w_sum;
        w_co  = w_sum_co;
      end
      OP_SHR: begin
        w_res = {w_ci, ba[N-1:1]};
        w_co  = ba[0];
      end
      OP_SHL: begin
        w_res = {ba[N-2:0], w_ci};
        w_co  = ba[N-1];
      end
      OP_NOT:  w_res = ~ba;
      OP_AND:  w_res = ba & bb;
      OP_OR:   w_res = ba | bb;
      OP_XOR:  w_res = ba ^ bb;
      OP_CMP:  w_res = ba ^ bb;
      default: w_res = '0;
    endcase
  end

  // An accepted op's flags take priority over a concurrent flag clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_res   <= '0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_flags <= 4'b0000;
    end else begin
      r_valid <= wvalid;
      r_we    <= wvalid && (bop != OP_CMP);
      if (wvalid) begin
        r_res   <= w_res;
        r_flags <= {w_co, w_gt, w_eq, (w_res == '0)};
      end else if (wclrf) begin
        r_flags <= 4'b0000;
      end
    end
  end

  assign bres       = r_res;
  assign wres_valid = r_valid;
  assign wres_we    = r_we;
  assign bflags     = r_flags;

endmodule

// File: tb/tb_jalu_reg.sv
// Directed scoreboard bench for jalu_reg: each step pushes its expected
// registered outputs, which are popped and checked one edge later.
module tb_jalu_reg;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SHR = 3'b001;
  localparam logic [2:0] SHL = 3'b010;
  localparam logic [2:0] NOT = 3'b011;
  localparam logic [2:0] AND = 3'b100;
  localparam logic [2:0] OR  = 3'b101;
  localparam logic [2:0] XOR = 3'b110;
  localparam logic [2:0] CMP = 3'b111;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [3:0] flags;
    logic       valid;
    logic       we;
  } exp_t;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       wvalid = 1'b0;
  logic [2:0] bop = 3'b000;
  logic [7:0] ba = 8'h00;
  logic [7:0] bb = 8'h00;
  logic       wuse_cf = 1'b0;
  logic       wclrf = 1'b0;
  logic [7:0] bres;
  logic       wres_valid;
  logic       wres_we;
  logic [3:0] bflags;

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;

  jalu_reg #(.N(8)) dut (
    .wclk(wclk), .wrst(wrst), .wvalid(wvalid), .bop(bop), .ba(ba), .bb(bb),
    .wuse_cf(wuse_cf), .wclrf(wclrf), .bres(bres), .wres_valid(wres_valid),
    .wres_we(wres_we), .bflags(bflags)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput();
    exp_t e;
    testCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard-empty observed=%0d expected=1", expQ.size());
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      testCount++;
      assert (bres === e.res) else begin
        failCount++;
        $error("[TB] FAIL %s.bres observed=%h expected=%h", e.tag, bres, e.res);
      end
      testCount++;
      assert (bflags === e.flags) else begin
        failCount++;
        $error("[TB] FAIL %s.bflags observed=%b expected=%b", e.tag, bflags, e.flags);
      end
      testCount++;
      assert (wres_valid === e.valid) else begin
        failCount++;
        $error("[TB] FAIL %s.wres_valid observed=%b expected=%b", e.tag, wres_valid, e.valid);
      end
      testCount++;
      assert (wres_we === e.we) else begin
        failCount++;
        $error("[TB] FAIL %s.wres_we observed=%b expected=%b", e.tag, wres_we, e.we);
      end
    end
  endtask

  // Drive one cycle of inputs, push its expectation, then check after the edge.
  task automatic applyStimulus(
    input string      tag,
    input logic       rst,
    input logic       valid,
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       useCf,
    input logic       clrf,
    input logic [7:0] expRes,
    input logic [3:0] expFlags,
    input logic       expValid,
    input logic       expWe
  );
    exp_t e;
    @(negedge wclk);
    wrst    = rst;
    wvalid  = valid;
    bop     = op;
    ba      = a;
    bb      = b;
    wuse_cf = useCf;
    wclrf   = clrf;
    e.tag   = tag;
    e.res   = expRes;
    e.flags = expFlags;
    e.valid = expValid;
    e.we    = expWe;
    expQ.push_back(e);
    @(posedge wclk);
    #1;
    checkOutput();
  endtask

  initial begin
    //              tag         rst v  op   A      B      cf clr  res    CAEZ     vld we
    applyStimulus("reset",      1, 0, ADD, 8'd0,  8'd0,  0, 0, 8'd0,  4'b0000, 0, 0);
    applyStimulus("add200+100", 0, 1, ADD, 8'd200,8'd100,0, 0, 8'd44, 4'b1100, 1, 1);
    applyStimulus("addChain",   0, 1, ADD, 8'd1,  8'd1,  1, 0, 8'd3,  4'b0010, 1, 1);
    applyStimulus("shr81",      0, 1, SHR, 8'h81, 8'h00, 1, 0, 8'h40, 4'b1100, 1, 1);
    applyStimulus("shl80",      0, 1, SHL, 8'h80, 8'h00, 1, 0, 8'h01, 4'b1100, 1, 1);
    applyStimulus("shrCarryIn", 0, 1, SHR, 8'h02, 8'h00, 1, 0, 8'h81, 4'b0100, 1, 1);
    applyStimulus("cmpEq",      0, 1, CMP, 8'd5,  8'd5,  0, 0, 8'd0,  4'b0011, 1, 0);
    applyStimulus("cmpGt",      0, 1, CMP, 8'd9,  8'd3,  0, 0, 8'd10, 4'b0100, 1, 0);
    applyStimulus("idle1",      0, 0, ADD, 8'hFF, 8'hFF, 0, 0, 8'd10, 4'b0100, 0, 0);
    applyStimulus("idle2",      0, 0, XOR, 8'h12, 8'h34, 1, 0, 8'd10, 4'b0100, 0, 0);
    applyStimulus("idle3",      0, 0, CMP, 8'h00, 8'h00, 0, 0, 8'd10, 4'b0100, 0, 0);
    applyStimulus("clrAlone",   0, 0, ADD, 8'h00, 8'h00, 0, 1, 8'd10, 4'b0000, 0, 0);
    applyStimulus("clrAdd255",  0, 1, ADD, 8'd255,8'd1,  0, 1, 8'd0,  4'b1101, 1, 1);
    applyStimulus("clrPreC",    0, 1, ADD, 8'h10, 8'h20, 1, 1, 8'h31, 4'b0000, 1, 1);
    applyStimulus("rstDrop",    1, 1, ADD, 8'd1,  8'd2,  0, 0, 8'd0,  4'b0000, 0, 0);
    applyStimulus("add1+2",     0, 1, ADD, 8'd1,  8'd2,  0, 0, 8'd3,  4'b0000, 1, 1);
    applyStimulus("notF0",      0, 1, NOT, 8'hF0, 8'h3C, 0, 0, 8'h0F, 4'b0100, 1, 1);
    applyStimulus("andF0",      0, 1, AND, 8'hF0, 8'h3C, 0, 0, 8'h30, 4'b0100, 1, 1);
    applyStimulus("orF0",       0, 1, OR,  8'hF0, 8'h3C, 0, 0, 8'hFC, 4'b0100, 1, 1);
    applyStimulus("xorF0",      0, 1, XOR, 8'hF0, 8'h3C, 0, 0, 8'hCC, 4'b0100, 1, 1);
    applyStimulus("idleAfter",  0, 0, ADD, 8'h00, 8'h00, 0, 0, 8'hCC, 4'b0100, 0, 0);
    testCount++;
    assert (expQ.size() == 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard-drain observed=%0d expected=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
